// File: rtl/wb8_bus_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the address decoder.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb8_bus_arbiter_if;
    logic        I_m0_cyc;
    logic        I_m0_stb;
    logic        I_m0_we;
    logic [31:0] I_m0_adr;
    logic [7:0]  I_m0_dat;
    logic [7:0]  O_m0_dat;
    logic        O_m0_ack;
    logic        O_m0_stall;

    logic        I_m1_cyc;
    logic        I_m1_stb;
    logic        I_m1_we;
    logic [31:0] I_m1_adr;
    logic [7:0]  I_m1_dat;
    logic [7:0]  O_m1_dat;
    logic        O_m1_ack;
    logic        O_m1_stall;

    logic        O_wb_cyc;
    logic        O_wb_stb;
    logic        O_wb_we;
    logic [31:0] O_wb_adr;
    logic [7:0]  O_wb_dat;
    logic [7:0]  I_wb_dat;
    logic        I_wb_ack;
    logic        I_wb_stall;

    logic [1:0]  O_grant;
    logic        O_timeout;

    modport slave (
        input  I_m0_cyc, I_m0_stb, I_m0_we, I_m0_adr, I_m0_dat,
        output O_m0_dat, O_m0_ack, O_m0_stall,
        input  I_m1_cyc, I_m1_stb, I_m1_we, I_m1_adr, I_m1_dat,
        output O_m1_dat, O_m1_ack, O_m1_stall,
        output O_wb_cyc, O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat,
        input  I_wb_dat, I_wb_ack, I_wb_stall,
        output O_grant, O_timeout
    );

    modport master (
        output I_m0_cyc, I_m0_stb, I_m0_we, I_m0_adr, I_m0_dat,
        input  O_m0_dat, O_m0_ack, O_m0_stall,
        output I_m1_cyc, I_m1_stb, I_m1_we, I_m1_adr, I_m1_dat,
        input  O_m1_dat, O_m1_ack, O_m1_stall,
        input  O_wb_cyc, O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat,
        output I_wb_dat, I_wb_ack, I_wb_stall,
        input  O_grant, O_timeout
    );
endinterface

// File: rtl/wb8_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter with a per-request watchdog that
// acks with ERR_DATA when no slave answers within TIMEOUT cycles.
module wb8_bus_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned TIMEOUT_BITS = 8,
    parameter logic [7:0]  ERR_DATA     = 8'hFF
) (
    input logic              I_wb_clk,
    input logic              I_reset_n,
    wb8_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0] TMO = TIMEOUT_BITS'(TIMEOUT);

    state_t                  state;
    logic [1:0]              grant;
    logic                    last_m1;
    logic                    outstanding;
    logic [TIMEOUT_BITS-1:0] cnt;

    logic g0, g1, granted;
    logic sel_cyc, sel_stb;
    logic slave_ack, expire, ack_deliv, accept, leave;

    always_comb begin
        g0        = grant[0];
        g1        = grant[1];
        granted   = g0 | g1;
        sel_cyc   = (g0 & bus.I_m0_cyc) | (g1 & bus.I_m1_cyc);
        sel_stb   = (g0 & bus.I_m0_stb) | (g1 & bus.I_m1_stb);
        // A slave ack only counts against an outstanding request and beats the watchdog.
        slave_ack = granted & outstanding & bus.I_wb_ack;
        expire    = granted & (cnt == TMO) & ~slave_ack;
        ack_deliv = slave_ack | expire;
        accept    = sel_stb & ~bus.I_wb_stall & ~expire;
        leave     = granted & ~sel_cyc;
    end

    assign bus.O_wb_cyc   = sel_cyc;
    assign bus.O_wb_stb   = sel_stb & ~expire;
    assign bus.O_wb_we    = g1 ? bus.I_m1_we  : bus.I_m0_we;
    assign bus.O_wb_adr   = g1 ? bus.I_m1_adr : bus.I_m0_adr;
    assign bus.O_wb_dat   = g1 ? bus.I_m1_dat : bus.I_m0_dat;

    assign bus.O_m0_dat   = (g0 & expire) ? ERR_DATA : bus.I_wb_dat;
    assign bus.O_m0_ack   = g0 & ack_deliv;
    assign bus.O_m0_stall = g0 ? bus.I_wb_stall : bus.I_m0_stb;

    assign bus.O_m1_dat   = (g1 & expire) ? ERR_DATA : bus.I_wb_dat;
    assign bus.O_m1_ack   = g1 & ack_deliv;
    assign bus.O_m1_stall = g1 ? bus.I_wb_stall : bus.I_m1_stb;

    assign bus.O_grant    = grant;
    assign bus.O_timeout  = expire;

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            last_m1     <= 1'b1;
            outstanding <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.I_m0_cyc && (!bus.I_m1_cyc || last_m1)) begin
                        state   <= GRANT0;
                        grant   <= 2'b01;
                        last_m1 <= 1'b0;
                    end else if (bus.I_m1_cyc) begin
                        state   <= GRANT1;
                        grant   <= 2'b10;
                        last_m1 <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (!bus.I_m0_cyc) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                GRANT1: begin
                    if (!bus.I_m1_cyc) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase

            // A new acceptance outranks a same-cycle ack so pipelined beats keep the flag set.
            if (!granted || leave) begin
                outstanding <= 1'b0;
            end else if (accept) begin
                outstanding <= 1'b1;
            end else if (ack_deliv) begin
                outstanding <= 1'b0;
            end

            if (!granted || leave || ack_deliv) begin
                cnt <= '0;
            end else if (outstanding || (sel_stb && bus.I_wb_stall)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb8_bus_arbiter.sv
// Directed bench for wb8_bus_arbiter with a short watchdog (TIMEOUT=4);
// inputs change 2 time units after each rising edge, outputs are checked 1 unit later.
module tb_wb8_bus_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    wb8_bus_arbiter_if bus();

    wb8_bus_arbiter #(
        .TIMEOUT      (4),
        .TIMEOUT_BITS (8),
        .ERR_DATA     (8'hFF)
    ) dut (
        .I_wb_clk  (clk),
        .I_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.I_m0_cyc = 0; bus.I_m0_stb = 0; bus.I_m0_we = 0; bus.I_m0_adr = 0; bus.I_m0_dat = 0;
        bus.I_m1_cyc = 0; bus.I_m1_stb = 0; bus.I_m1_we = 0; bus.I_m1_adr = 0; bus.I_m1_dat = 0;
        bus.I_wb_dat = 0; bus.I_wb_ack = 0; bus.I_wb_stall = 0;

        // Reset state
        #3;
        check("rst_grant",   32'(bus.O_grant),    0);
        check("rst_wb_cyc",  32'(bus.O_wb_cyc),   0);
        check("rst_wb_stb",  32'(bus.O_wb_stb),   0);
        check("rst_timeout", 32'(bus.O_timeout),  0);
        check("rst_m0_ack",  32'(bus.O_m0_ack),   0);
        check("rst_m0_stall",32'(bus.O_m0_stall), 0);
        check("rst_m1_stall",32'(bus.O_m1_stall), 0);
        tick();
        rst_n = 1'b1;

        // Single m0 write, slave acks two cycles after acceptance
        tick();
        bus.I_m0_cyc = 1; bus.I_m0_stb = 1; bus.I_m0_we = 1;
        bus.I_m0_adr = 32'hFFFF_FFF0; bus.I_m0_dat = 8'h5A;
        #1;
        check("t1_grant_pre", 32'(bus.O_grant),    0);
        check("t1_stall_pre", 32'(bus.O_m0_stall), 1);
        check("t1_cyc_pre",   32'(bus.O_wb_cyc),   0);
        tick(); #1;
        check("t1_grant",  32'(bus.O_grant),   32'h1);
        check("t1_wb_cyc", 32'(bus.O_wb_cyc),  1);
        check("t1_wb_stb", 32'(bus.O_wb_stb),  1);
        check("t1_wb_we",  32'(bus.O_wb_we),   1);
        check("t1_wb_adr", bus.O_wb_adr,       32'hFFFF_FFF0);
        check("t1_wb_dat", 32'(bus.O_wb_dat),  32'h5A);
        check("t1_m1_ack", 32'(bus.O_m1_ack),  0);
        check("t1_m1_stall", 32'(bus.O_m1_stall), 0);
        tick(); bus.I_m0_stb = 0; #1;
        check("t1_ack_early", 32'(bus.O_m0_ack), 0);
        tick(); bus.I_wb_ack = 1; #1;
        check("t1_ack", 32'(bus.O_m0_ack), 1);
        check("t1_m1_ack_b", 32'(bus.O_m1_ack), 0);
        tick(); bus.I_wb_ack = 0; bus.I_m0_cyc = 0; #1;
        check("t1_ack_one", 32'(bus.O_m0_ack), 0);
        check("t1_grant_hold", 32'(bus.O_grant), 32'h1);
        tick(); #1;
        check("t1_grant_idle", 32'(bus.O_grant), 0);

        // Tie after reset goes to m0, then round-robin to m1 and back
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.I_m0_cyc = 1; bus.I_m0_stb = 0; bus.I_m0_we = 0;
        bus.I_m1_cyc = 1; bus.I_m1_stb = 1; bus.I_m1_adr = 32'h0000_0040;
        #1;
        check("t2_m1_stall_pre", 32'(bus.O_m1_stall), 1);
        check("t2_m0_stall_pre", 32'(bus.O_m0_stall), 0);
        tick(); #1;
        check("t2_grant_m0", 32'(bus.O_grant), 32'h1);
        check("t2_m1_stall", 32'(bus.O_m1_stall), 1);
        check("t2_m1_ack",   32'(bus.O_m1_ack), 0);
        tick(); bus.I_m0_cyc = 0; #1;
        check("t2_grant_hold", 32'(bus.O_grant), 32'h1);
        check("t2_wb_cyc_drop", 32'(bus.O_wb_cyc), 0);
        tick(); #1;
        check("t2_dead_cycle", 32'(bus.O_grant), 0);
        check("t2_m1_stall_idle", 32'(bus.O_m1_stall), 1);
        tick(); #1;
        check("t2_grant_m1", 32'(bus.O_grant), 32'h2);
        check("t2_m1_stall_g", 32'(bus.O_m1_stall), 0);
        check("t2_wb_stb_m1", 32'(bus.O_wb_stb), 1);
        check("t2_wb_adr_m1", bus.O_wb_adr, 32'h0000_0040);
        tick(); bus.I_m1_cyc = 0; bus.I_m1_stb = 0; #1;
        check("t2_grant_m1_hold", 32'(bus.O_grant), 32'h2);
        tick(); #1;
        check("t2_idle2", 32'(bus.O_grant), 0);
        bus.I_m0_cyc = 1; bus.I_m1_cyc = 1;
        tick(); #1;
        check("t2_rr_m0", 32'(bus.O_grant), 32'h1);
        tick(); bus.I_m0_cyc = 0; bus.I_m1_cyc = 0;
        tick(); #1;
        check("t2_idle3", 32'(bus.O_grant), 0);

        // Watchdog: unacked m0 read expires on the 5th cycle after acceptance
        bus.I_m0_cyc = 1; bus.I_m0_stb = 1; bus.I_m0_we = 0; bus.I_m0_adr = 32'h0000_1000;
        tick(); #1;
        check("t3_grant", 32'(bus.O_grant), 32'h1);
        check("t3_wb_stb", 32'(bus.O_wb_stb), 1);
        tick(); bus.I_m0_stb = 0; #1;
        check("t3_c1_ack", 32'(bus.O_m0_ack), 0);
        for (int i = 2; i <= 4; i++) begin
            tick(); #1;
            check("t3_wait_ack", 32'(bus.O_m0_ack), 0);
            check("t3_wait_to",  32'(bus.O_timeout), 0);
        end
        tick(); bus.I_wb_dat = 8'h33; #1;
        check("t3_exp_ack", 32'(bus.O_m0_ack), 1);
        check("t3_exp_dat", 32'(bus.O_m0_dat), 32'hFF);
        check("t3_exp_to",  32'(bus.O_timeout), 1);
        tick(); #1;
        check("t3_post_ack", 32'(bus.O_m0_ack), 0);
        check("t3_post_to",  32'(bus.O_timeout), 0);
        tick();
        tick(); bus.I_wb_ack = 1; #1;
        check("t3_late_ack", 32'(bus.O_m0_ack), 0);
        check("t3_late_to",  32'(bus.O_timeout), 0);

        // Slave ack in the expiry cycle wins
        tick(); bus.I_wb_ack = 0; bus.I_m0_stb = 1;
        tick(); bus.I_m0_stb = 0;
        tick(); tick(); tick();
        #1;
        check("t4_pre_ack", 32'(bus.O_m0_ack), 0);
        tick(); bus.I_wb_ack = 1; bus.I_wb_dat = 8'h77; #1;
        check("t4_ack",  32'(bus.O_m0_ack), 1);
        check("t4_dat",  32'(bus.O_m0_dat), 32'h77);
        check("t4_to",   32'(bus.O_timeout), 0);
        tick(); bus.I_wb_ack = 0; #1;
        check("t4_post_ack", 32'(bus.O_m0_ack), 0);
        check("t4_post_to",  32'(bus.O_timeout), 0);
        tick(); bus.I_m0_cyc = 0;
        tick(); #1;
        check("t4_idle", 32'(bus.O_grant), 0);

        // Pipelined m1 reads, acks one cycle after each beat
        bus.I_m1_cyc = 1; bus.I_m1_stb = 1; bus.I_m1_we = 0; bus.I_m1_adr = 32'h0000_0020;
        tick(); #1;
        check("t5_grant", 32'(bus.O_grant), 32'h2);
        check("t5_adr0",  bus.O_wb_adr, 32'h0000_0020);
        tick(); bus.I_m1_adr = 32'h0000_0021; bus.I_wb_ack = 1; bus.I_wb_dat = 8'h11;
        bus.I_m0_cyc = 1; bus.I_m0_stb = 1; #1;
        check("t5_ack1",     32'(bus.O_m1_ack), 1);
        check("t5_dat1",     32'(bus.O_m1_dat), 32'h11);
        check("t5_adr1",     bus.O_wb_adr, 32'h0000_0021);
        check("t5_m0_stall", 32'(bus.O_m0_stall), 1);
        check("t5_m0_ack",   32'(bus.O_m0_ack), 0);
        tick(); bus.I_m1_stb = 0; bus.I_wb_dat = 8'h22; #1;
        check("t5_ack2", 32'(bus.O_m1_ack), 1);
        check("t5_dat2", 32'(bus.O_m1_dat), 32'h22);
        tick(); bus.I_wb_ack = 0; #1;
        check("t5_ack_end", 32'(bus.O_m1_ack), 0);
        tick(); bus.I_wb_ack = 1; #1;
        check("t5_spurious", 32'(bus.O_m1_ack), 0);
        check("t5_sp_to",    32'(bus.O_timeout), 0);
        tick(); bus.I_wb_ack = 0; bus.I_m1_cyc = 0; bus.I_m0_cyc = 0; bus.I_m0_stb = 0;
        tick(); #1;
        check("t5_idle", 32'(bus.O_grant), 0);

        // Asynchronous reset during an outstanding m1 request
        bus.I_m1_cyc = 1; bus.I_m1_stb = 1; bus.I_m1_adr = 32'h0000_0030;
        tick(); #1;
        check("t6_grant_m1", 32'(bus.O_grant), 32'h2);
        tick(); bus.I_m1_stb = 0; #1;
        check("t6_cyc_pre", 32'(bus.O_wb_cyc), 1);
        rst_n = 1'b0; bus.I_wb_ack = 1; #1;
        check("t6_rst_grant", 32'(bus.O_grant), 0);
        check("t6_rst_cyc",   32'(bus.O_wb_cyc), 0);
        check("t6_rst_ack",   32'(bus.O_m1_ack), 0);
        bus.I_wb_ack = 0; bus.I_m0_cyc = 1;
        tick(); #1;
        check("t6_held", 32'(bus.O_grant), 0);
        rst_n = 1'b1;
        tick(); #1;
        check("t6_tie_m0", 32'(bus.O_grant), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb8_bus_arbiter.md
Name: wb8_bus_arbiter

Overview:
- Two-master arbiter for the shared 8-bit Wishbone bus.
- Master 0 is the CPU; master 1 is a DMA/debug master.
- Round-robin grant, held for the whole CYC. STB/STALL/ACK are forwarded only for the granted master.
- A bus watchdog ends any request that no slave acknowledges within TIMEOUT cycles, so the CPU cannot hang on unmapped or broken slaves.
- Sits between the masters and the existing address decoder; the decoder sees a single master.

Parameters:
- TIMEOUT, 255: cycles a request may remain unacknowledged before the watchdog acks it (1..2^TIMEOUT_BITS-1).
- TIMEOUT_BITS, 8: width of the watchdog counter.
- ERR_DATA, 8'hFF: read data returned on a watchdog-generated ack.

Ports:
- I_wb_clk  in  1  bus clock
- I_reset_n  in  1  asynchronous active-low reset
- I_m0_cyc, I_m0_stb, I_m0_we  in  1 each  master 0 bus controls
- I_m0_adr  in  32  master 0 address
- I_m0_dat  in  8  master 0 write data
- O_m0_dat  out  8  master 0 read data
- O_m0_ack  out  1  master 0 acknowledge
- O_m0_stall  out  1  master 0 stall
- I_m1_cyc, I_m1_stb, I_m1_we, I_m1_adr, I_m1_dat, O_m1_dat, O_m1_ack, O_m1_stall: same as master 0, for master 1
- O_wb_cyc, O_wb_stb, O_wb_we  out  1 each  to decoder/slaves
- O_wb_adr  out  32  to decoder/slaves
- O_wb_dat  out  8  to decoder/slaves
- I_wb_dat  in  8  from decoder
- I_wb_ack  in  1  from decoder
- I_wb_stall  in  1  from decoder
- O_grant  out  2  one-hot current grant, 00 = idle
- O_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (asynchronous, I_reset_n=0):
  - state IDLE, O_grant=00, last-granted=master 1, so master 0 wins the first tie.
  - outstanding=0, counter=0, O_timeout=0.
  - O_wb_cyc/stb=0, all acks 0, stalls 0.
- States:
  - IDLE: no grant.
    - If exactly one I_mX_cyc=1, grant that master next cycle.
    - If both, grant the master that was not last granted.
  - GRANT0 / GRANT1: grant held while that master's cyc=1.
    - When its cyc=0 (sampled), return to IDLE. This is one dead cycle between tenancies; there is no direct GRANTx-to-GRANTy transition.
- Forwarding while granted (combinational):
  - O_wb_cyc/stb/we/adr/dat come from the granted master.
  - O_mX_dat = I_wb_dat.
  - O_mX_ack = I_wb_ack & outstanding.
  - O_mX_stall = I_wb_stall.
- IDLE, or master not granted:
  - O_wb_cyc=0, O_wb_stb=0.
  - That master sees ack=0 and stall=1 whenever its stb=1.
- Outstanding flag:
  - Set on stb & !stall of the granted master.
  - Cleared on the cycle where ack is delivered to the master (slave or watchdog).
  - Set and clear in the same cycle leaves it set (back-to-back pipelined request).
  - Slave acks while outstanding=0 are discarded, never forwarded. This covers late acks after a timeout.
- Watchdog counter:
  - Increments each cycle while granted and (outstanding | (stb & I_wb_stall)).
  - Resets to 0 on any delivered ack, on leaving a GRANT state, and in IDLE.
  - On the cycle after it reaches TIMEOUT:
    - O_mX_ack=1 and O_mX_dat=ERR_DATA to the granted master;
    - O_wb_stb forced 0;
    - O_timeout=1 for one cycle;
    - outstanding cleared, counter cleared.
  - If a slave ack arrives in the same cycle as expiry, the slave ack wins: real data, no O_timeout.
- A master dropping cyc with an outstanding request abandons it: outstanding is cleared and the arbiter returns to IDLE.
- Reset mid-tenancy: everything returns to the reset values immediately. The next grant follows the reset tie rule.

Test Plan:
- Only m0 cyc/stb, adr 0xFFFFFFF0, write 0x5A, slave acks after 2 cycles -> O_grant=01 one cycle after cyc; O_wb_adr=0xFFFFFFF0, O_wb_dat=0x5A; O_m0_ack one cycle; m1 untouched.
- m0 and m1 raise cyc in the same cycle after reset -> m0 granted, m1_stall=1. m0 drops cyc -> one IDLE cycle, then O_grant=10. Repeat with both -> m0 granted (round-robin).
- m0 read to an unmapped address (never acked), TIMEOUT=4 -> O_m0_ack=1 with O_m0_dat=0xFF at the 5th cycle after acceptance; O_timeout pulses once; a slave ack 3 cycles later is not forwarded.
- Slave ack arrives in the exact expiry cycle -> m0 gets I_wb_dat, O_timeout stays 0.
- Pipelined reads: m1 issues two stb beats with stall=0, acks 1 cycle apart -> two acks forwarded, outstanding stays set between them, counter never exceeds 1.
- I_reset_n pulsed low while GRANT1 with a request outstanding -> O_grant=00, O_wb_cyc=0 asynchronously. After release, both requesting -> m0 granted.
